// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and constants for the AES core arbiter
// Contents:
//   state_t                 arbiter FSM states (IDLE, RUN, RESP)
//   AES_W                   AES block / key width in bits
//   NUM_REQ, ID_W           number of requesters and requester index width
//   TIMEOUT_CYCLES_DEFAULT  default RUN-cycle limit for the optional timeout
//   onehot_to_idx()         converts a one-hot grant into a requester index
package aes_ctrl_pkg;

  localparam int AES_W                  = 128;
  localparam int NUM_REQ                = 2;
  localparam int ID_W                   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - request, response and core-side bus of the AES core arbiter
// Signals:
//   req_valid/req_ready       per-requester job handshake (bit i = requester i)
//   req_data/req_key          packed plaintext/key, requester i at [i*AES_W +: AES_W]
//   rsp_valid/rsp_ready       result handshake; rsp_id names the owning requester
//   rsp_data                  ciphertext
//   core_en                   enable to the shared AES core
//   core_data_in/core_key_in  operands to the core
//   core_data_out(_valid)     core result and its strobe
// Modports:
//   slave   the arbiter
//   master  the environment (requesters, result consumer and AES core)
interface aes_core_arbiter_if;
  import aes_ctrl_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*AES_W-1:0] req_data;
  logic [NUM_REQ*AES_W-1:0] req_key;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [AES_W-1:0]         rsp_data;
  logic                     core_en;
  logic [AES_W-1:0]         core_data_in;
  logic [AES_W-1:0]         core_key_in;
  logic [AES_W-1:0]         core_data_out;
  logic                     core_data_out_valid;

  modport slave (
    input  req_valid, req_data, req_key, rsp_ready, core_data_out, core_data_out_valid,
    output req_ready, rsp_valid, rsp_id, rsp_data, core_en, core_data_in, core_key_in
  );

  modport master (
    output req_valid, req_data, req_key, rsp_ready, core_data_out, core_data_out_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_data, core_en, core_data_in, core_key_in
  );

endinterface

// File: rtl/aes_rr_arb.sv
// rtl/aes_rr_arb.sv - round-robin requester selection
// Ports:
//   req    in   NUM_REQ  request vector
//   last   in   ID_W     index of the requester granted last
//   grant  out  NUM_REQ  one-hot grant, zero when no request is pending
module aes_rr_arb
  import aes_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant
);

  int idx;

  // Scan from the lowest priority (the last winner) towards the highest
  // (the one right after it); the final hit in the scan therefore wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (req[idx]) grant = NUM_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin arbiter sharing one AES core between requesters
// Ports:
//   AES_clk      in   rising-edge clock
//   AES_rst      in   synchronous active-high reset
//   bus          aes_core_arbiter_if.slave (requests, response, core operands/result)
//   busy         out  high whenever the FSM is not in IDLE
//   timeout_err  out  one-cycle pulse when a RUN job is aborted
// Configuration:
//   AES_ARB_TIMEOUT_EN  when defined, a RUN job that gets no core result within
//                       TIMEOUT_CYCLES cycles is aborted; otherwise RUN waits forever.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                AES_clk,
  input  logic                AES_rst,
  aes_core_arbiter_if.slave   bus,
  output logic                busy,
  output logic                timeout_err
);

  state_t             state, state_nxt;
  logic [AES_W-1:0]   data_q, key_q, rsp_data_q;
  logic [ID_W-1:0]    id_q, last_q, gidx;
  logic [NUM_REQ-1:0] grant, req_ready_c;
  logic               timeout_hit;

  aes_rr_arb u_rr_arb (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign gidx = onehot_to_idx(grant);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt;

  // Held at zero outside RUN, so it starts from zero on every RUN entry and
  // holds (k-1) during RUN cycle k.
  always_ff @(posedge AES_clk) begin
    if (AES_rst || state != RUN) run_cnt <= '0;
    else                         run_cnt <= run_cnt + 1'b1;
  end

  // A core result arriving in the last allowed cycle beats the timeout.
  assign timeout_hit = (state == RUN) && !bus.core_data_out_valid &&
                       (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (bus.core_data_out_valid) state_nxt = RESP;
        else if (timeout_hit)        state_nxt = IDLE;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // No acceptance can be signalled while the reset is being applied.
    if (AES_rst) req_ready_c = '0;
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state      <= IDLE;
      data_q     <= '0;
      key_q      <= '0;
      rsp_data_q <= '0;
      id_q       <= '0;
      // Pretend the highest index won last so requester 0 takes the first tie.
      last_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && |bus.req_valid) begin
        data_q <= bus.req_data[int'(gidx)*AES_W +: AES_W];
        key_q  <= bus.req_key[int'(gidx)*AES_W +: AES_W];
        id_q   <= gidx;
      end
      if (state == RUN && bus.core_data_out_valid) rsp_data_q <= bus.core_data_out;
      // The pointer moves only when a job leaves the arbiter, by response or abort.
      if ((state == RESP && bus.rsp_ready) || timeout_hit) last_q <= id_q;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.core_en      = (state == RUN);
  assign bus.core_data_in = data_q;
  assign bus.core_key_in  = key_q;
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign busy             = (state != IDLE);
  assign timeout_err      = timeout_hit && !AES_rst;

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, maximum RUN cycles before a job is aborted (used only under AES_ARB_TIMEOUT_EN).
REQ-002 AES_clk  in  1  single clock; all logic SHALL be rising-edge on AES_clk.
REQ-003 AES_rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  2  per-requester job request (bit 0 = requester 0).
REQ-005 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-006 req_data  in  256  plaintext; [127:0] requester 0, [255:128] requester 1.
REQ-007 req_key  in  256  key; same packing as req_data.
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  result consumer accept.
REQ-010 rsp_id  out  1  requester index owning the result.
REQ-011 rsp_data  out  128  ciphertext.
REQ-012 core_en  out  1  enable to the shared AES core.
REQ-013 core_data_in / core_key_in  out  128 each  operands to the core.
REQ-014 core_data_out  in  128; core_data_out_valid  in  1  core result and strobe.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  one-cycle abort pulse.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, RUN and RESP.
REQ-018 IDLE: if any req_valid bit is high, grant one requester, assert its req_ready in that same cycle, capture its data/key into internal registers, and go to RUN.
REQ-019 Arbitration SHALL be round-robin: with both bits high, grant the requester not granted last; with one bit high, grant that one.
REQ-020 req_ready SHALL be 0 in RUN and RESP; requests SHALL wait there without loss.
REQ-021 RUN: core_en=1 and core_data_in/core_key_in SHALL be driven from the captured registers, constant for the whole of RUN.
REQ-022 core_en SHALL rise in the cycle after the accepting handshake (latency 1).
REQ-023 In RUN, when core_data_out_valid=1, capture core_data_out into rsp_data, drive core_en=0 from the next cycle, and go to RESP.
REQ-024 RESP: rsp_valid=1 with rsp_data/rsp_id stable until rsp_valid&rsp_ready; then go to IDLE and update the last-grant pointer.
REQ-025 core_data_out_valid outside RUN SHALL be ignored.
REQ-026 core_en SHALL be low for at least one cycle between consecutive jobs (guaranteed by passing through IDLE).
REQ-027 A new req_valid in the RESP exit cycle SHALL NOT be granted until the following IDLE cycle.

Reset
REQ-028 When AES_rst=1 at a clock edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, core_en=0, core_data_in=0, core_key_in=0, busy=0, timeout_err=0, and the last-grant pointer set so that requester 0 wins the first tie.
REQ-029 Reset during RUN or RESP SHALL abandon the job silently; no response and no timeout_err.

Configuration
REQ-030 With AES_ARB_TIMEOUT_EN defined: a counter cleared on entry to RUN counts RUN cycles; if it reaches TIMEOUT_CYCLES without core_data_out_valid, drop core_en, pulse timeout_err for 1 cycle, produce no response, go to IDLE, and update the pointer.
REQ-031 Without AES_ARB_TIMEOUT_EN: RUN waits indefinitely, no counter is built, and timeout_err is tied 0.
REQ-032 If core_data_out_valid and the timeout fall in the same cycle, valid SHALL win.

Structure
REQ-033 Package aes_ctrl_pkg SHALL hold the state enum, AES_W=128, NUM_REQ=2 and the TIMEOUT_CYCLES default.
REQ-034 Round-robin selection SHALL be a sub-module aes_rr_arb (inputs: request vector, last-grant pointer; output: one-hot grant).

Verification
REQ-035 The bench SHALL use a core stub returning data^key 40 cycles after core_en rises.
REQ-036 Single job: req_valid=01, data=000000ca_00000000_00000000_00000000, key=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc -> req_ready=01 in 1 cycle; core_en high 1 cycle later; rsp_valid, rsp_id=0, rsp_data=aa2bdb8a_bff6a5e8_caa9ba3e_bc1e2acc.
REQ-037 Contention: req_valid=11 held for 3 jobs -> grant order 0,1,0; rsp_id sequence 0,1,0.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=00, core_en=0 throughout.
REQ-039 Reset mid-RUN: AES_rst=1 at RUN cycle 20 -> next edge core_en=0, busy=0, no rsp_valid; the next tie is won by requester 0.
REQ-040 With AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16 and the stub never answering -> timeout_err pulses exactly at RUN cycle 16, then IDLE; without the macro, busy stays 1.
